cache_direct_param: RTL and testbench

Parametrised direct-mapped instruction cache with multi-word lines, sitting between the IF-stage PC and main memory.
- Lookup is combinational: a hit returns the word in the same cycle.
- On a miss, an FSM stalls the pipeline, refills the whole line one word per beat over a valid-handshake memory port, then replays the requested word.
- Adds a flush, saturating hit/miss counters, and configurable line count and line size.

---
 rtl/cache_direct_param.sv | 156 +++++++++++++++
 tb/tb_cache_direct_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_direct_param.sv
// Direct-mapped instruction cache with multi-word lines.
// A lookup is combinational, so a hit returns its word in the same cycle.
// A miss stalls the fetch. The whole line is then refilled one word per
// MM_Valid beat, and the requested word is returned in a one-cycle DONE state.
// The cache also supports a flush and saturating hit/miss counters.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RESET      synchronous active-low reset
//   PC         fetch byte address (PC[1:0] ignored)
//   Req        fetch request valid
//   Flush      invalidate all lines (honoured in IDLE only)
//   MM_Valid   MM_Data carries the word at MM_Addr this cycle
//   MM_Data    refill data from main memory
//   HitWrite   Data_Cache valid; also used as the PC/IFID write enable
//   Data_Cache fetched instruction, 0 when HitWrite=0
//   MM_Req     refill in progress
//   MM_Addr    byte address of the word being requested, 0 when idle
//   CNT_HIT    saturating lookup-hit count
//   CNT_MISS   saturating miss count
module cache_direct_param #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      PC,
  input  logic             Req,
  input  logic             Flush,
  input  logic             MM_Valid,
  input  logic [31:0]      MM_Data,
  output logic             HitWrite,
  output logic [31:0]      Data_Cache,
  output logic             MM_Req,
  output logic [31:0]      MM_Addr,
  output logic [CNT_W-1:0] CNT_HIT,
  output logic [CNT_W-1:0] CNT_MISS
);
  localparam int OB    = $clog2(WORDS_PER_LINE);
  localparam int IB    = $clog2(NUM_LINES);
  localparam int OBW   = (OB > 0) ? OB : 1;
  localparam int TAG_W = 30 - OB - IB;
  localparam int AW    = IB + OB;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t             state_reg;
  logic [29:0]        lat_word_reg;   // latched word address of the missing fetch
  logic [OBW-1:0]     cnt_reg;        // refill word counter
  logic [NUM_LINES-1:0] valid_reg;
  logic [CNT_W-1:0]   hit_cnt_reg;
  logic [CNT_W-1:0]   miss_cnt_reg;

  logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
  logic [31:0]        data_mem [NUM_LINES*WORDS_PER_LINE];

  logic [29:0]        pc_word;
  logic [IB-1:0]      pc_index, lat_index;
  logic [TAG_W-1:0]   pc_tag, lat_tag;
  logic [AW-1:0]      pc_addr, lat_addr, wr_addr, rd_addr;
  logic [29:0]        mm_word;
  logic               hit, last_beat, beat;
  logic               unused_pc;

  assign pc_word   = PC[31:2];
  assign unused_pc = ^PC[1:0];

  assign pc_index  = pc_word[OB +: IB];
  assign pc_tag    = pc_word[OB+IB +: TAG_W];
  assign lat_index = lat_word_reg[OB +: IB];
  assign lat_tag   = lat_word_reg[OB+IB +: TAG_W];

  // With one word per line there is no offset field, so the data array
  // index is the line index alone.
  generate
    if (OB > 0) begin : g_offset
      assign pc_addr  = {pc_index, pc_word[OB-1:0]};
      assign lat_addr = {lat_index, lat_word_reg[OB-1:0]};
      assign wr_addr  = {lat_index, cnt_reg};
      assign mm_word  = {lat_word_reg[29:OB], cnt_reg};
    end else begin : g_no_offset
      assign pc_addr  = pc_index;
      assign lat_addr = lat_index;
      assign wr_addr  = lat_index;
      assign mm_word  = lat_word_reg;
    end
  endgenerate

  assign hit = (state_reg == IDLE) && Req && !Flush &&
               valid_reg[pc_index] && (tag_mem[pc_index] == pc_tag);

  assign beat      = (state_reg == REFILL) && MM_Valid;
  assign last_beat = beat && (cnt_reg == OBW'(WORDS_PER_LINE - 1));

  // The single read port serves either the live lookup or the replay of the
  // refilled word in DONE.
  assign rd_addr    = (state_reg == DONE) ? lat_addr : pc_addr;
  assign HitWrite   = hit || (state_reg == DONE);
  assign Data_Cache = HitWrite ? data_mem[rd_addr] : 32'd0;

  assign MM_Req   = (state_reg == REFILL);
  assign MM_Addr  = MM_Req ? {mm_word, 2'b00} : 32'd0;
  assign CNT_HIT  = hit_cnt_reg;
  assign CNT_MISS = miss_cnt_reg;

  // Data and tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (RESET && beat) begin
      data_mem[wr_addr] <= MM_Data;
    end
    if (RESET && last_beat) begin
      tag_mem[lat_index] <= lat_tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      valid_reg    <= '0;
      cnt_reg      <= '0;
      lat_word_reg <= '0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Flush) begin
            valid_reg <= '0;
          end else if (hit) begin
            if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
          end else if (Req) begin
            if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
            lat_word_reg <= pc_word;
            cnt_reg      <= '0;
            state_reg    <= REFILL;
          end
        end
        REFILL: begin
          if (last_beat) begin
            valid_reg[lat_index] <= 1'b1;
            state_reg            <= DONE;
          end else if (beat) begin
            cnt_reg <= cnt_reg + OBW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_direct_param.sv
// Randomised scoreboard bench for cache_direct_param.
// The stimulus process computes each fetch's expected word, stall range and
// counter values from a line-level model and queues them. The monitor process
// checks the DUT on every falling edge against the head of that queue.
// A second instance with 4-bit counters receives the same stimulus and is
// used to check counter saturation.
module tb_cache_direct_param;
  localparam int N       = 8;
  localparam int W       = 4;
  localparam int OB      = 2;
  localparam int IB      = 3;
  localparam int SAT_MAX = 15;

  logic        clk = 1'b0;
  logic        RESET, Req, Flush, MM_Valid;
  logic [31:0] PC, MM_Data;
  logic        HitWrite, MM_Req;
  logic [31:0] Data_Cache, MM_Addr;
  logic [19:0] CNT_HIT, CNT_MISS;
  logic [3:0]  sat_hit, sat_miss;
  logic        sat_unused_hw, sat_unused_req;
  logic [31:0] sat_unused_data, sat_unused_addr;

  cache_direct_param dut (
    .CLK(clk), .RESET(RESET), .PC(PC), .Req(Req), .Flush(Flush),
    .MM_Valid(MM_Valid), .MM_Data(MM_Data), .HitWrite(HitWrite),
    .Data_Cache(Data_Cache), .MM_Req(MM_Req), .MM_Addr(MM_Addr),
    .CNT_HIT(CNT_HIT), .CNT_MISS(CNT_MISS)
  );

  cache_direct_param #(.CNT_W(4)) dut_sat (
    .CLK(clk), .RESET(RESET), .PC(PC), .Req(Req), .Flush(Flush),
    .MM_Valid(MM_Valid), .MM_Data(MM_Data), .HitWrite(sat_unused_hw),
    .Data_Cache(sat_unused_data), .MM_Req(sat_unused_req), .MM_Addr(sat_unused_addr),
    .CNT_HIT(sat_hit), .CNT_MISS(sat_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] base;
    bit          miss;
    int          smin;
    int          smax;
    int          hit_after;
    int          miss_after;
  } sb_item_t;

  sb_item_t sb_q[$];

  // Reference model: one valid flag and tag per line, and plain counts.
  bit          valid_m [N];
  logic [31:0] tag_m   [N];
  int          hit_m, miss_m;

  // Stimulus-owned controls.
  bit mon_en    = 1'b0;
  bit chk_reset = 1'b0;
  int mode      = 0;   // 0: MM_Valid tied 1, 1: random, 2: fixed gap pattern

  // Monitor-owned tallies.
  int n_checks = 0;
  int n_fail   = 0;
  int stall    = 0;
  int beats    = 0;
  bit cnt_pending = 1'b0;
  sb_item_t cur;

  function automatic int sat(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Memory responder: the data returned for a word is its own byte address.
  // Garbage is driven while MM_Valid is low, so a refill that writes during a
  // gap stores a wrong word.
  initial begin
    int pat [7];
    int pi;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    pi = 0;
    MM_Valid = 1'b1;
    MM_Data  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!MM_Req) pi = 0;
      case (mode)
        1:       MM_Valid = 1'($urandom_range(0, 1));
        2:       begin MM_Valid = MM_Req ? 1'(pat[pi % 7]) : 1'b1; if (MM_Req) pi++; end
        default: MM_Valid = 1'b1;
      endcase
      MM_Data = MM_Valid ? MM_Addr : $urandom;
    end
  end

  // Monitor.
  always @(negedge clk) begin
    if (chk_reset) begin
      chk("rst_hitwrite", 32'(HitWrite), 32'd0);
      chk("rst_data", Data_Cache, 32'd0);
      chk("rst_mm_req", 32'(MM_Req), 32'd0);
      chk("rst_mm_addr", MM_Addr, 32'd0);
      chk("rst_cnt_hit", 32'(CNT_HIT), 32'd0);
      chk("rst_cnt_miss", 32'(CNT_MISS), 32'd0);
      chk("rst_sat_hit", 32'(sat_hit), 32'd0);
      stall = 0; beats = 0; cnt_pending = 1'b0;
    end else if (!mon_en) begin
      stall = 0; beats = 0; cnt_pending = 1'b0;
    end else begin
      if (cnt_pending) begin
        chk("cnt_hit", 32'(CNT_HIT), 32'(cur.hit_after));
        chk("cnt_miss", 32'(CNT_MISS), 32'(cur.miss_after));
        chk("sat_cnt_hit", 32'(sat_hit), 32'(sat(cur.hit_after)));
        chk("sat_cnt_miss", 32'(sat_miss), 32'(sat(cur.miss_after)));
        cnt_pending = 1'b0;
      end
      if (!MM_Req) begin
        chk("mm_addr_idle", MM_Addr, 32'd0);
      end else if (MM_Valid) begin
        if (sb_q.size() == 0) begin
          chk("refill_without_fetch", 32'(MM_Req), 32'd0);
        end else begin
          chk("mm_addr_beat", MM_Addr, sb_q[0].base + 32'(4 * beats));
        end
        beats++;
      end
      if (HitWrite) begin
        if (sb_q.size() == 0) begin
          chk("hit_without_fetch", 32'(HitWrite), 32'd0);
        end else begin
          cur = sb_q.pop_front();
          chk("data", Data_Cache, cur.data);
          chk("beats", 32'(beats), cur.miss ? 32'(W) : 32'd0);
          n_checks++;
          if (stall < cur.smin || stall > cur.smax) begin
            n_fail++;
            $display("FAIL stall pc=%h actual=%0d required=[%0d,%0d]", cur.pc, stall, cur.smin, cur.smax);
          end
          $display("fetch pc=%h %s data=%h stall=%0d hits=%0d misses=%0d",
                   cur.pc, cur.miss ? "miss" : "hit ", Data_Cache, stall, cur.hit_after, cur.miss_after);
          cnt_pending = 1'b1;
        end
        stall = 0;
        beats = 0;
      end else begin
        chk("data_zero", Data_Cache, 32'd0);
        if (Req && !Flush) stall++;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) valid_m[i] = 1'b0;
    hit_m  = 0;
    miss_m = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input int smin, input int smax);
    int          idx;
    logic [31:0] t;
    bit          hit;
    sb_item_t    it;
    idx = int'((pc >> (OB + 2)) % N);
    t   = pc >> (OB + IB + 2);
    hit = valid_m[idx] && (tag_m[idx] == t);
    if (hit) hit_m++;
    else begin
      miss_m++;
      valid_m[idx] = 1'b1;
      tag_m[idx]   = t;
    end
    it.pc         = pc;
    it.data       = pc & ~32'd3;
    it.base       = pc & ~32'(W * 4 - 1);
    it.miss       = !hit;
    it.smin       = hit ? 0 : smin;
    it.smax       = hit ? 0 : smax;
    it.hit_after  = hit_m;
    it.miss_after = miss_m;
    sb_q.push_back(it);
    PC  = pc;
    Req = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (HitWrite) break;
      if (c > 400) begin
        $display("FAIL fetch_timeout pc=%h actual=no HitWrite required=HitWrite within 400 cycles", pc);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input bit with_req);
    Flush = 1'b1;
    Req   = with_req;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    Req   = 1'b0;
    for (int i = 0; i < N; i++) valid_m[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    Req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    RESET = 1'b0; Req = 1'b0; Flush = 1'b0; PC = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b1;
    chk_reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset = 1'b0;
    mon_en = 1'b1;

    // Cold miss, same-line hit, conflict eviction and re-miss.
    fetch(32'h40, W + 1, W + 1);
    fetch(32'h48, 0, 0);
    fetch(32'hC0, W + 1, W + 1);
    fetch(32'h40, W + 1, W + 1);

    // Refill with MM_Valid gaps 1,0,0,1,1,0,1: lookup plus seven refill cycles.
    mode = 2;
    fetch(32'h100, 8, 8);
    mode = 0;

    // Flush with a request to a cached line, then the same fetch misses.
    do_flush(1'b1);
    fetch(32'h100, W + 1, W + 1);
    idle(2);

    // Reset after two refill beats.
    mon_en = 1'b0;
    PC  = 32'h200;
    Req = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    RESET = 1'b0;
    Req   = 1'b0;
    @(posedge clk);
    #1;
    RESET = 1'b1;
    chk_reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset = 1'b0;
    model_reset();
    sb_q.delete();
    mon_en = 1'b1;
    fetch(32'h40, W + 1, W + 1);

    // Twenty hits drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) fetch(32'h40 + 32'(4 * (i % W)), 0, 0);

    // Random traffic over a few tags so hits, conflicts and flushes mix.
    mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        do_flush(1'($urandom_range(0, 1)));
      end else begin
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 2) * 37 + 1) << 7) |
             (32'($urandom_range(0, N - 1)) << 4) |
             (32'($urandom_range(0, W - 1)) << 2) |
             32'($urandom_range(0, 3));
        fetch(pc, W + 1, 400);
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
